// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared cache constants and line-fill state encoding
//
// Purpose: common definitions for the cache miss path: way count, way index
// width, default address/data geometry and the line-fill FSM state type.
// Ports: none (package).
package cache_pkg;

  localparam int WAYS       = 8;
  localparam int WAY_W      = 3;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;
  localparam int OFF_W_DEF  = 2;
  localparam int SET_W_DEF  = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    TAG   = 2'd2,
    DONE  = 2'd3
  } fill_state_e;

endpackage

// File: rtl/cache_line_fill_beat_counter.sv
// rtl/cache_line_fill_beat_counter.sv - beat sequencer for one cache line fill
//
// Purpose: tracks which word of the line the next memory beat carries and how
// many beats have been accepted, so the fill ends on beat count rather than
// on address (the word index wraps when the fill starts mid-line).
// Ports:
//   clk, reset   clock, async active-low reset
//   load         start a new fill, word index <- start
//   start        first word index of the fill
//   inc          a beat was accepted this cycle
//   beat         word index of the current beat
//   last         the current beat is the final one of the line
module fill_beat_counter
  import cache_pkg::*;
#(
  parameter int OFF_W = OFF_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [OFF_W-1:0] start,
  input  logic             inc,
  output logic [OFF_W-1:0] beat,
  output logic             last
);

  logic [OFF_W-1:0] beat_q, beat_d;
  logic [OFF_W-1:0] cnt_q, cnt_d;

  always_comb begin
    beat_d = beat_q;
    cnt_d  = cnt_q;
    if (load) begin
      beat_d = start;
      cnt_d  = '0;
    end else if (inc) begin
      beat_d = beat_q + 1'b1;
      cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_q <= '0;
      cnt_q  <= '0;
    end else begin
      beat_q <= beat_d;
      cnt_q  <= cnt_d;
    end
  end

  assign beat = beat_q;
  // cnt_q counts accepted beats; all-ones means this is the last of 2^OFF_W.
  assign last = &cnt_q;

endmodule

// File: rtl/cache_line_fill.sv
// rtl/cache_line_fill.sv - miss-side line-fill controller for the 8-way cache
//
// Purpose: on a read miss, latch the victim way and line address, strobe the
// replacement unit, fetch the whole line over a req/ack memory port, write
// each word into the data array, then write the tag/valid bit for the way.
// Option macro: CACHE_FILL_CWF_EN enables critical-word-first ordering and
// the crit_valid early-restart output.
// Ports:
//   clk, reset                 clock, async active-low reset
//   miss_valid/miss_addr       miss request in, miss_ready = idle
//   victim_way, repl_update    replacement unit choice and advance strobe
//   mem_req/mem_addr           memory read request and beat address
//   mem_ack/mem_rdata          beat accept and read data
//   arr_we/set/way/word/wdata  data array write port
//   tag_we/tag_wdata           tag write plus valid set for arr_way
//   fill_done, busy            line installed pulse, controller not idle
//   crit_valid                 (CWF builds only) first beat delivered
module cache_line_fill
  import cache_pkg::*;
#(
  parameter  int ADDR_W = ADDR_W_DEF,
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int OFF_W  = OFF_W_DEF,
  parameter  int SET_W  = SET_W_DEF,
  localparam int TAG_W  = ADDR_W - SET_W - OFF_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              miss_valid,
  input  logic [ADDR_W-1:0] miss_addr,
  output logic              miss_ready,
  input  logic [WAY_W-1:0]  victim_way,
  output logic              repl_update,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              arr_we,
  output logic [SET_W-1:0]  arr_set,
  output logic [WAY_W-1:0]  arr_way,
  output logic [OFF_W-1:0]  arr_word,
  output logic [DATA_W-1:0] arr_wdata,
  output logic              tag_we,
  output logic [TAG_W-1:0]  tag_wdata,
`ifdef CACHE_FILL_CWF_EN
  output logic              crit_valid,
`endif
  output logic              fill_done,
  output logic              busy
);

  localparam int LINE_W = ADDR_W - OFF_W;

  fill_state_e       state_q;
  logic [LINE_W-1:0] line_q;
  logic [WAY_W-1:0]  way_q;

  logic              accept;
  logic              beat_ack;
  logic [OFF_W-1:0]  start_beat;
  logic [OFF_W-1:0]  beat;
  logic              last_beat;

  assign accept   = (state_q == IDLE) && miss_valid;
  // Acks outside FETCH are ignored because mem_req is low there.
  assign beat_ack = (state_q == FETCH) && mem_ack;

`ifdef CACHE_FILL_CWF_EN
  assign start_beat = miss_addr[OFF_W-1:0];
`else
  assign start_beat = '0;
`endif

  fill_beat_counter #(.OFF_W(OFF_W)) u_beat_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .start (start_beat),
    .inc   (beat_ack),
    .beat  (beat),
    .last  (last_beat)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      line_q  <= '0;
      way_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (miss_valid) begin
            line_q  <= miss_addr[ADDR_W-1:OFF_W];
            way_q   <= victim_way;
            state_q <= FETCH;
          end
        end
        FETCH: begin
          if (mem_ack && last_beat) state_q <= TAG;
        end
        TAG:     state_q <= DONE;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef CACHE_FILL_CWF_EN
  // Armed at acceptance, consumed by the first accepted beat.
  logic crit_pend_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      crit_pend_q <= 1'b0;
    end else if (accept) begin
      crit_pend_q <= 1'b1;
    end else if (beat_ack) begin
      crit_pend_q <= 1'b0;
    end
  end

  assign crit_valid = beat_ack && crit_pend_q;
`endif

  // Strobes decode the async-reset state register, so a reset mid-fill drops
  // mem_req at once and no tag write can follow a partial line.
  assign miss_ready  = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign repl_update = accept;
  assign mem_req     = (state_q == FETCH);
  assign mem_addr    = {line_q, beat};
  assign arr_we      = beat_ack;
  assign arr_set     = line_q[SET_W-1:0];
  assign arr_way     = way_q;
  assign arr_word    = beat;
  assign arr_wdata   = mem_rdata;
  assign tag_we      = (state_q == TAG);
  assign tag_wdata   = line_q[LINE_W-1:SET_W];
  assign fill_done   = (state_q == DONE);

endmodule

// File: tb/tb_cache_line_fill.sv
// tb/tb_cache_line_fill.sv - self-checking bench for cache_line_fill
module tb_cache_line_fill;

`ifdef CACHE_FILL_CWF_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        miss_valid = 1'b0;
  logic [15:0] miss_addr = '0;
  logic        miss_ready;
  logic [2:0]  victim_way = '0;
  logic        repl_update;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        arr_we;
  logic [5:0]  arr_set;
  logic [2:0]  arr_way;
  logic [1:0]  arr_word;
  logic [31:0] arr_wdata;
  logic        tag_we;
  logic [7:0]  tag_wdata;
  logic        fill_done;
  logic        busy;
`ifdef CACHE_FILL_CWF_EN
  logic        crit_valid;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  cache_line_fill dut (
    .clk        (clk),
    .reset      (reset),
    .miss_valid (miss_valid),
    .miss_addr  (miss_addr),
    .miss_ready (miss_ready),
    .victim_way (victim_way),
    .repl_update(repl_update),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .arr_we     (arr_we),
    .arr_set    (arr_set),
    .arr_way    (arr_way),
    .arr_word   (arr_word),
    .arr_wdata  (arr_wdata),
    .tag_we     (tag_we),
    .tag_wdata  (tag_wdata),
`ifdef CACHE_FILL_CWF_EN
    .crit_valid (crit_valid),
`endif
    .fill_done  (fill_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One complete fill; entered and left at posedge+1 of an IDLE cycle.
  // Expected beat order: word k of the fill is (start + k) mod 4.
  task automatic run_fill(input logic [15:0] addr, input logic [2:0] way,
                          input int min_stall, input int max_stall,
                          input bit poke_miss, input bit hold_in_done);
    logic [7:0] etag = addr[15:8];
    logic [5:0] eset = addr[7:2];
    int start = CWF ? int'(addr[1:0]) : 0;
    int stalls = 0;
    int acc_cyc;
    miss_valid = 1'b1;
    miss_addr  = addr;
    victim_way = way;
    @(negedge clk);
    acc_cyc = cyc;
    chk("accept_ready", miss_ready, 1);
    chk("accept_repl", repl_update, 1);
    next_cycle();
    miss_valid = 1'b0;
    victim_way = ~way;
    miss_addr  = 16'($urandom);
    for (int k = 0; k < 4; k++) begin
      int stall = int'($urandom_range(max_stall, min_stall));
      int w = (start + k) % 4;
      logic [1:0] w2 = w[1:0];
      logic [31:0] d;
      for (int s = 0; s < stall; s++) begin
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        miss_valid = poke_miss;
        @(negedge clk);
        stalls++;
        chk("stall_req", mem_req, 1);
        chk("stall_addr", mem_addr, {addr[15:2], w2});
        chk("stall_we", arr_we, 0);
        chk("stall_repl", repl_update, 0);
        if (poke_miss) chk("stall_ready", miss_ready, 0);
        next_cycle();
      end
      d          = $urandom;
      mem_ack    = 1'b1;
      mem_rdata  = d;
      miss_valid = poke_miss;
      victim_way = 3'($urandom);
      @(negedge clk);
      chk("beat_req", mem_req, 1);
      chk("beat_addr", mem_addr, {addr[15:2], w2});
      chk("beat_we", arr_we, 1);
      chk("beat_word", arr_word, w2);
      chk("beat_set", arr_set, eset);
      chk("beat_way", arr_way, way);
      chk("beat_wdata", arr_wdata, d);
      chk("beat_repl", repl_update, 0);
`ifdef CACHE_FILL_CWF_EN
      chk("beat_crit", crit_valid, (k == 0));
`endif
      next_cycle();
    end
    mem_ack    = 1'($urandom);
    miss_valid = poke_miss;
    @(negedge clk);
    chk("tag_we", tag_we, 1);
    chk("tag_wdata", tag_wdata, etag);
    chk("tag_way", arr_way, way);
    chk("tag_set", arr_set, eset);
    chk("tag_arr_we", arr_we, 0);
    chk("tag_done", fill_done, 0);
    chk("tag_ready", miss_ready, 0);
    next_cycle();
    miss_valid = poke_miss | hold_in_done;
    @(negedge clk);
    chk("done_pulse", fill_done, 1);
    chk("done_tag_we", tag_we, 0);
    chk("done_repl", repl_update, 0);
    chk("done_ready", miss_ready, 0);
    chk("done_busy", busy, 1);
    chk("done_latency", cyc - acc_cyc, 6 + stalls);
    next_cycle();
    mem_ack = 1'b0;
    if (!hold_in_done) miss_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_ready", miss_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_repl", repl_update, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_we", arr_we, 0);
    chk("rst_tag_we", tag_we, 0);
    chk("rst_done", fill_done, 0);
    chk("rst_way", arr_way, 0);
    chk("rst_set", arr_set, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_tag", tag_wdata, 0);
    next_cycle();
    reset = 1'b1;
    next_cycle();

    // Ack while idle is ignored
    mem_ack = 1'b1;
    @(negedge clk);
    chk("idle_ack_we", arr_we, 0);
    chk("idle_ack_req", mem_req, 0);
    next_cycle();
    mem_ack = 1'b0;

    // Reference fill, ack tied high
    run_fill(16'h1234, 3'd5, 0, 0, 1'b0, 1'b0);
    // Three-cycle stall on every beat
    run_fill(16'($urandom), 3'($urandom), 3, 3, 1'b0, 1'b0);
    // Miss held during fetch and done: ignored, then accepted back-to-back
    run_fill(16'h5A5A, 3'd2, 0, 2, 1'b1, 1'b1);
    run_fill(16'hABCF, 3'd6, 0, 1, 1'b0, 1'b0);

    // Reset asserted after two beats
    miss_valid = 1'b1;
    miss_addr  = 16'h7E41;
    victim_way = 3'd3;
    next_cycle();
    miss_valid = 1'b0;
    mem_ack    = 1'b1;
    next_cycle();
    next_cycle();
    mem_ack = 1'b0;
    chk("pre_rst_req", mem_req, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_req", mem_req, 0);
    chk("mid_rst_ready", miss_ready, 1);
    chk("mid_rst_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_rst_tag_we", tag_we, 0);
      chk("mid_rst_done", fill_done, 0);
      next_cycle();
    end
    reset   = 1'b1;
    mem_ack = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", miss_ready, 1);
    chk("post_rst_req", mem_req, 0);
    chk("post_rst_we", arr_we, 0);
    next_cycle();
    mem_ack = 1'b0;

    // Random fills
    for (int n = 0; n < 8; n++) begin
      run_fill(16'($urandom), 3'($urandom), 0, 2, 1'($urandom), 1'($urandom));
    end
    miss_valid = 1'b0;
    next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
